// File: rtl/alu_share_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU sharing block.
package alu_share_arbiter_pkg;

  // Controller states: wait for a command, drive the ALU, hold the response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Bit positions inside the 4-bit status vector {log, err, under, over}.
  localparam int OVER  = 0;
  localparam int UNDER = 1;
  localparam int ERR   = 2;
  localparam int LOG   = 3;

  // Opcodes understood by the shared ALU; anything above LT raises err.
  localparam logic [3:0] ADD = 4'd0;
  localparam logic [3:0] SUB = 4'd1;
  localparam logic [3:0] SHL = 4'd2;
  localparam logic [3:0] SHR = 4'd3;
  localparam logic [3:0] EQ  = 4'd4;
  localparam logic [3:0] GT  = 4'd5;
  localparam logic [3:0] LT  = 4'd6;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-input round-robin grant selection with the last-grant history bit.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic       o_any,
  output logic       o_winner
);

  logic r_last;

  // Winner: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    o_any    = |i_req;
    o_winner = i_req[1];
    if (i_req == 2'b11) begin
      o_winner = ~r_last;
    end
  end

  // History bit starts at 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (i_update) begin
      r_last <= o_winner;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two valid/ready requesters.
//
// Handshake rule (all channels): a transfer happens on a rising edge where
// valid and ready are both high. Command ready is only offered in IDLE and
// only to the arbitration winner; response valid is only raised in RESP and
// only towards the requester that owns the in-flight operation.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int N     = 12,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [N-1:0]     req0_op1,
  input  logic [N-1:0]     req0_op2,
  input  logic [3:0]       req0_cmd,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [N-1:0]     req1_op1,
  input  logic [N-1:0]     req1_op2,
  input  logic [3:0]       req1_cmd,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [N-1:0]     resp_data,
  output logic [3:0]       resp_flags,
  output logic [N-1:0]     alu_op1,
  output logic [N-1:0]     alu_op2,
  output logic [3:0]       alu_cmd,
  input  logic [N-1:0]     alu_out,
  input  logic [3:0]       alu_flags,
  output logic             busy,
  output logic [CNT_W-1:0] err_cnt
);

  state_t           r_state;
  state_t           w_next;
  logic [N-1:0]     r_op1;
  logic [N-1:0]     r_op2;
  logic [3:0]       r_cmd;
  logic             r_owner;
  logic [N-1:0]     r_data;
  logic [3:0]       r_flags;
  logic [CNT_W-1:0] r_err_cnt;

  logic w_any;
  logic w_winner;
  logic w_accept;
  logic w_resp_hs;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    ({req1_valid, req0_valid}),
    .i_update (w_accept),
    .o_any    (w_any),
    .o_winner (w_winner)
  );

  // Command acceptance and response completion strobes; ready is held low while in reset.
  always_comb begin
    w_accept   = (r_state == IDLE) && rst_n && w_any;
    req0_ready = w_accept && !w_winner;
    req1_ready = w_accept && w_winner;
    w_resp_hs  = (r_state == RESP) && (r_owner ? resp1_ready : resp0_ready);
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = EXEC;
      EXEC:    w_next = RESP;
      RESP:    if (w_resp_hs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Operand latch on accept; operands keep driving the ALU until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op1   <= '0;
      r_op2   <= '0;
      r_cmd   <= '0;
      r_owner <= 1'b0;
    end else if (w_accept) begin
      r_op1   <= w_winner ? req1_op1 : req0_op1;
      r_op2   <= w_winner ? req1_op2 : req0_op2;
      r_cmd   <= w_winner ? req1_cmd : req0_cmd;
      r_owner <= w_winner;
    end
  end

  // Result capture and saturating error count at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data    <= '0;
      r_flags   <= '0;
      r_err_cnt <= '0;
    end else if (r_state == EXEC) begin
      r_data  <= alu_out;
      r_flags <= alu_flags;
      if (alu_flags[ERR] && (r_err_cnt != {CNT_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  // Output mapping.
  always_comb begin
    alu_op1     = r_op1;
    alu_op2     = r_op2;
    alu_cmd     = r_cmd;
    resp_data   = r_data;
    resp_flags  = r_flags;
    resp0_valid = (r_state == RESP) && !r_owner;
    resp1_valid = (r_state == RESP) && r_owner;
    busy        = (r_state != IDLE);
    err_cnt     = r_err_cnt;
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with an external ALU model and a response scoreboard.
module tb_alu_share_arbiter;

  localparam int N     = 12;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             req0_valid, req0_ready;
  logic [N-1:0]     req0_op1, req0_op2;
  logic [3:0]       req0_cmd;
  logic             req1_valid, req1_ready;
  logic [N-1:0]     req1_op1, req1_op2;
  logic [3:0]       req1_cmd;
  logic             resp0_valid, resp0_ready;
  logic             resp1_valid, resp1_ready;
  logic [N-1:0]     resp_data;
  logic [3:0]       resp_flags;
  logic [N-1:0]     alu_op1, alu_op2;
  logic [3:0]       alu_cmd;
  logic [N-1:0]     alu_out;
  logic [3:0]       alu_flags;
  logic             busy;
  logic [CNT_W-1:0] err_cnt;

  int total = 0;
  int bad   = 0;
  // Expected response entry: {owner, flags[3:0], data[11:0]}.
  logic [16:0] exp_q[$];
  logic [16:0] mon_e;
  logic        mon_h0, mon_h1;

  alu_share_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_op1    (req0_op1),
    .req0_op2    (req0_op2),
    .req0_cmd    (req0_cmd),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_op1    (req1_op1),
    .req1_op2    (req1_op2),
    .req1_cmd    (req1_cmd),
    .resp0_valid (resp0_valid),
    .resp0_ready (resp0_ready),
    .resp1_valid (resp1_valid),
    .resp1_ready (resp1_ready),
    .resp_data   (resp_data),
    .resp_flags  (resp_flags),
    .alu_op1     (alu_op1),
    .alu_op2     (alu_op2),
    .alu_cmd     (alu_cmd),
    .alu_out     (alu_out),
    .alu_flags   (alu_flags),
    .busy        (busy),
    .err_cnt     (err_cnt)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- external ALU model {log, err, under, over} ----------------
  always_comb begin
    logic [N:0] sum;
    alu_out   = '0;
    alu_flags = 4'b0000;
    sum       = '0;
    case (alu_cmd)
      4'd0: begin
        sum          = {1'b0, alu_op1} + {1'b0, alu_op2};
        alu_out      = sum[N-1:0];
        alu_flags[0] = sum[N];
      end
      4'd1: begin
        alu_out      = alu_op1 - alu_op2;
        alu_flags[1] = (alu_op1 < alu_op2);
      end
      4'd2: alu_out = alu_op1 << alu_op2[3:0];
      4'd3: alu_out = alu_op1 >> alu_op2[3:0];
      4'd4: alu_flags[3] = (alu_op1 == alu_op2);
      4'd5: alu_flags[3] = (alu_op1 > alu_op2);
      4'd6: alu_flags[3] = (alu_op1 < alu_op2);
      default: alu_flags[2] = 1'b1;
    endcase
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one command, wait (bounded) for its grant, and record the expected response.
  task automatic issue(input logic who, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [3:0] c, input logic [N-1:0] ed, input logic [3:0] ef,
                       output int waited);
    bit got;
    got    = 1'b0;
    waited = 0;
    @(posedge clk); #1;
    if (who) begin
      req1_valid = 1'b1; req1_op1 = a; req1_op2 = b; req1_cmd = c;
    end else begin
      req0_valid = 1'b1; req0_op1 = a; req0_op2 = b; req0_cmd = c;
    end
    while (!got && waited < 20) begin
      @(negedge clk);
      if (who ? req1_ready : req0_ready) got = 1'b1;
      else waited++;
    end
    check("grant_timeout", {31'd0, got}, 32'd1);
    if (got) exp_q.push_back({who, ef, ed});
    @(posedge clk); #1;
    if (who) req1_valid = 1'b0;
    else     req0_valid = 1'b0;
  endtask

  // Wait (bounded) until every expected response is consumed and the block is idle.
  task automatic wait_drain();
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    while (!done && n < 50) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) done = 1'b1;
      else n++;
    end
    check("drain_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      mon_h0 = resp0_valid && resp0_ready;
      mon_h1 = resp1_valid && resp1_ready;
      if (mon_h0 || mon_h1) begin
        check("resp_single_owner", {31'd0, resp0_valid && resp1_valid}, 32'd0);
        if (exp_q.size() == 0) begin
          check("resp_unexpected", {30'd0, mon_h1, mon_h0}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("resp_owner", {31'd0, resp1_valid}, {31'd0, mon_e[16]});
          check("resp_data",  {20'd0, resp_data},   {20'd0, mon_e[11:0]});
          check("resp_flags", {28'd0, resp_flags},  {28'd0, mon_e[15:12]});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int w;
    int ng;
    int gc[3];
    int gw[3];

    rst_n = 1'b1;
    req0_valid = 1'b0; req0_op1 = '0; req0_op2 = '0; req0_cmd = '0;
    req1_valid = 1'b0; req1_op1 = '0; req1_op2 = '0; req1_cmd = '0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    #1 rst_n = 1'b0;

    // Reset state, with both requesters asserting valid.
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    check("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    check("rst_resp_valid", {30'd0, resp1_valid, resp0_valid}, 32'd0);
    check("rst_resp_data", {20'd0, resp_data}, 32'd0);
    check("rst_resp_flags", {28'd0, resp_flags}, 32'd0);
    check("rst_alu_bus", {alu_cmd, alu_op2, alu_op1}, 32'd0);
    check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    // ADD with carry out from requester 0, latency and routing.
    issue(1'b0, 12'hFFF, 12'h002, 4'd0, 12'h001, 4'b0001, w);
    check("t1_ready_first_cycle", w, 0);
    @(negedge clk);
    check("t1_exec_busy", {31'd0, busy}, 32'd1);
    check("t1_exec_no_valid", {31'd0, resp0_valid}, 32'd0);
    check("t1_alu_op1", {20'd0, alu_op1}, 32'h0FFF);
    check("t1_alu_op2", {20'd0, alu_op2}, 32'h0002);
    @(negedge clk);
    check("t1_resp0_valid", {31'd0, resp0_valid}, 32'd1);
    check("t1_resp1_low", {31'd0, resp1_valid}, 32'd0);
    wait_drain();

    // SUB with borrow from requester 1.
    issue(1'b1, 12'h003, 12'h005, 4'd1, 12'hFFE, 4'b0010, w);
    wait_drain();
    check("t2_alu_op_hold", {20'd0, alu_op1}, 32'h0003);

    // Contention: both held valid after reset; grants alternate 0,1,0 three cycles apart.
    do_reset();
    ng = 0;
    for (int k = 0; k < 3; k++) begin gc[k] = -1; gw[k] = -1; end
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_op1 = 12'h001; req0_op2 = 12'h002; req0_cmd = 4'd0;
    req1_valid = 1'b1; req1_op1 = 12'h009; req1_op2 = 12'h004; req1_cmd = 4'd1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        if (ng < 3) begin gc[ng] = c; gw[ng] = req1_ready ? 1 : 0; end
        ng++;
        if (req1_ready) exp_q.push_back({1'b1, 4'b0000, 12'h005});
        else            exp_q.push_back({1'b0, 4'b0000, 12'h003});
      end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("t3_grant_count", ng, 3);
    check("t3_grant0_who", gw[0], 0);
    check("t3_grant0_cyc", gc[0], 0);
    check("t3_grant1_who", gw[1], 1);
    check("t3_grant1_cyc", gc[1], 3);
    check("t3_grant2_who", gw[2], 0);
    check("t3_grant2_cyc", gc[2], 6);
    wait_drain();

    // Compare and illegal opcodes; error counter saturation.
    issue(1'b0, 12'h007, 12'h007, 4'd4, 12'h000, 4'b1000, w);
    wait_drain();
    check("t4_err_cnt_0", {24'd0, err_cnt}, 32'd0);
    issue(1'b0, 12'h001, 12'h002, 4'd9, 12'h000, 4'b0100, w);
    wait_drain();
    check("t4_err_cnt_1", {24'd0, err_cnt}, 32'd1);
    for (int i = 0; i < 300; i++) begin
      issue(i[0], i[11:0], 12'h00A, 4'd9 + {2'b00, i[1:0]}, 12'h000, 4'b0100, w);
      if (i == 252) begin
        wait_drain();
        check("t4_err_cnt_fe", {24'd0, err_cnt}, 32'h0FE);
      end
    end
    wait_drain();
    check("t4_err_cnt_sat", {24'd0, err_cnt}, 32'h0FF);

    // Backpressure on response 0 while requester 1 waits.
    resp0_ready = 1'b0;
    issue(1'b0, 12'h010, 12'h020, 4'd0, 12'h030, 4'b0000, w);
    req1_valid = 1'b1; req1_op1 = 12'h005; req1_op2 = 12'h005; req1_cmd = 4'd1;
    w = 0;
    while (!resp0_valid && w < 10) begin @(negedge clk); w++; end
    check("t5_resp0_reached", {31'd0, resp0_valid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("t5_hold_valid", {31'd0, resp0_valid}, 32'd1);
      check("t5_hold_data", {20'd0, resp_data}, 32'h0030);
      check("t5_hold_flags", {28'd0, resp_flags}, 32'd0);
      check("t5_req1_blocked", {31'd0, req1_ready}, 32'd0);
    end
    @(posedge clk); #1 resp0_ready = 1'b1;
    @(negedge clk);
    check("t5_req1_blocked_hs", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    check("t5_req1_granted_after", {31'd0, req1_ready}, 32'd1);
    if (req1_ready) exp_q.push_back({1'b1, 4'b0000, 12'h000});
    @(posedge clk); #1 req1_valid = 1'b0;
    wait_drain();

    // Reset pulsed during EXEC: nothing is returned, then the block works again.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_op1 = 12'h001; req0_op2 = 12'h001; req0_cmd = 4'd0;
    w = 0;
    while (!req0_ready && w < 10) begin @(negedge clk); if (!req0_ready) w++; end
    check("t6_grant", {31'd0, req0_ready}, 32'd1);
    @(posedge clk); #1;
    check("t6_in_exec", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    check("t6_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    req0_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t6_no_resp", {30'd0, resp1_valid, resp0_valid}, 32'd0);
      check("t6_idle", {31'd0, busy}, 32'd0);
    end
    issue(1'b0, 12'h100, 12'h001, 4'd0, 12'h101, 4'b0000, w);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
